// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM preconditioner.
//   ULTRASOUND_CNT_CYCLE : length of one ultrasound period in CLK cycles
//   CNT_WIDTH            : width of the time counter and edge times
//   DUTY_WIDTH           : width of the filtered duty/phase values
//   state_e              : sequencing FSM states
//   calc_rise/calc_fall  : edge-time arithmetic, 9-bit wrap-around
package pwm_pkg;

  localparam int unsigned ULTRASOUND_CNT_CYCLE = 512;
  localparam int unsigned CNT_WIDTH            = 9;
  localparam int unsigned DUTY_WIDTH           = 8;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    WAIT_UPDATE
  } state_e;

  // Pulse is centred on phase*2; half the duty is placed before it.
  function automatic logic [CNT_WIDTH-1:0] calc_rise(input logic [DUTY_WIDTH-1:0] phase,
                                                     input logic [DUTY_WIDTH-1:0] duty);
    logic [CNT_WIDTH-1:0] phase_x2;
    logic [CNT_WIDTH-1:0] duty_half;
    phase_x2  = {phase, 1'b0};
    duty_half = CNT_WIDTH'(duty) >> 1;
    return phase_x2 - duty_half;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] calc_fall(input logic [CNT_WIDTH-1:0]  rise,
                                                     input logic [DUTY_WIDTH-1:0] duty);
    return rise + CNT_WIDTH'(duty);
  endfunction

endpackage

// File: rtl/pwm_generator.sv
// Single-channel PWM comparator.
// Drives PWM high while TIME_CNT lies in the half-open window [RISE, FALL), with the window
// allowed to wrap past the end of the ultrasound period. Output is registered, so it lags
// TIME_CNT by one cycle. RISE == FALL yields a permanently low output.
// Ports:
//   CLK, RST  : clock and synchronous active-high reset
//   TIME_CNT  : ultrasound period counter
//   RISE/FALL : committed edge times for this channel
//   PWM       : registered drive signal
module pwm_generator
  import pwm_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [CNT_WIDTH-1:0] TIME_CNT,
  input  logic [CNT_WIDTH-1:0] RISE,
  input  logic [CNT_WIDTH-1:0] FALL,
  output logic                 PWM
);

  logic pwm_d;
  logic pwm_q;

  always_comb begin
    pwm_d = 1'b0;
    if (RISE <= FALL) begin
      pwm_d = (TIME_CNT >= RISE) && (TIME_CNT < FALL);
    end else begin
      // Window wraps through the end of the period.
      pwm_d = (TIME_CNT >= RISE) || (TIME_CNT < FALL);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pwm_q <= 1'b0;
    end else begin
      pwm_q <= pwm_d;
    end
  end

  assign PWM = pwm_q;

endmodule

// File: rtl/pwm_preconditioner.sv
// Converts filtered per-transducer duty/phase values into rise/fall edge times and,
// optionally, per-transducer PWM drive signals.
// A fresh IN_VALID latches the inputs and walks one transducer per cycle into a shadow
// table; the table is committed to RISE/FALL atomically at the next UPDATE seen after the
// walk has finished, and OUT_VALID pulses for one cycle afterwards.
// Build option: define PWM_OUTPUT_EN to instantiate the per-channel comparators; without it
// PWM_OUT is tied low.
// Ports:
//   CLK, RST        : clock and synchronous active-high reset
//   TIME_CNT        : ultrasound period counter (0..511)
//   UPDATE          : one-cycle pulse while TIME_CNT == 511
//   IN_VALID        : one-cycle pulse marking DUTYS/PHASES as fresh
//   DUTYS, PHASES   : per-transducer duty and phase
//   RISE, FALL      : committed per-transducer edge times
//   OUT_VALID       : one-cycle pulse after a commit
//   PWM_OUT         : per-transducer drive signal
module pwm_preconditioner
  import pwm_pkg::*;
#(
  parameter int unsigned TRANS_NUM = 249
) (
  input  logic                                  CLK,
  input  logic                                  RST,
  input  logic [CNT_WIDTH-1:0]                  TIME_CNT,
  input  logic                                  UPDATE,
  input  logic                                  IN_VALID,
  input  logic [TRANS_NUM-1:0][DUTY_WIDTH-1:0]  DUTYS,
  input  logic [TRANS_NUM-1:0][DUTY_WIDTH-1:0]  PHASES,
  output logic [TRANS_NUM-1:0][CNT_WIDTH-1:0]   RISE,
  output logic [TRANS_NUM-1:0][CNT_WIDTH-1:0]   FALL,
  output logic                                  OUT_VALID,
  output logic [TRANS_NUM-1:0]                  PWM_OUT
);

  localparam int unsigned IdxW = (TRANS_NUM > 1) ? $clog2(TRANS_NUM) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(TRANS_NUM - 1);

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            commit;
  logic            calc_en;

  logic [TRANS_NUM-1:0][DUTY_WIDTH-1:0] dutys_q;
  logic [TRANS_NUM-1:0][DUTY_WIDTH-1:0] phases_q;
  logic [TRANS_NUM-1:0][CNT_WIDTH-1:0]  shadow_rise_q;
  logic [TRANS_NUM-1:0][CNT_WIDTH-1:0]  shadow_fall_q;
  logic [TRANS_NUM-1:0][CNT_WIDTH-1:0]  rise_q;
  logic [TRANS_NUM-1:0][CNT_WIDTH-1:0]  fall_q;
  logic                                 out_valid_q;

  logic [CNT_WIDTH-1:0] calc_rise_v;
  logic [CNT_WIDTH-1:0] calc_fall_v;

  // Sequencing FSM. UPDATE only matters once the walk has fully completed (registered
  // state WAIT_UPDATE); a new IN_VALID always restarts the walk, but a coincident commit
  // in WAIT_UPDATE still goes ahead with the old shadow table.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      CALC: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          state_d = WAIT_UPDATE;
          idx_d   = '0;
        end
      end
      WAIT_UPDATE: begin
        if (UPDATE) begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
    if (IN_VALID) begin
      state_d = CALC;
      idx_d   = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // A restart cycle writes nothing; the walk begins again from index 0 next cycle.
  assign calc_en     = (state_q == CALC) && !IN_VALID;
  assign calc_rise_v = calc_rise(phases_q[idx_q], dutys_q[idx_q]);
  assign calc_fall_v = calc_fall(calc_rise_v, dutys_q[idx_q]);

  always_ff @(posedge CLK) begin
    if (RST) begin
      dutys_q       <= '0;
      phases_q      <= '0;
      shadow_rise_q <= '0;
      shadow_fall_q <= '0;
      rise_q        <= '0;
      fall_q        <= '0;
      out_valid_q   <= 1'b0;
    end else begin
      out_valid_q <= commit;
      if (IN_VALID) begin
        dutys_q  <= DUTYS;
        phases_q <= PHASES;
      end
      if (calc_en) begin
        shadow_rise_q[idx_q] <= calc_rise_v;
        shadow_fall_q[idx_q] <= calc_fall_v;
      end
      if (commit) begin
        rise_q <= shadow_rise_q;
        fall_q <= shadow_fall_q;
      end
    end
  end

  assign RISE      = rise_q;
  assign FALL      = fall_q;
  assign OUT_VALID = out_valid_q;

`ifdef PWM_OUTPUT_EN
  for (genvar i = 0; i < int'(TRANS_NUM); i++) begin : g_pwm
    pwm_generator u_pwm_generator (
      .CLK      (CLK),
      .RST      (RST),
      .TIME_CNT (TIME_CNT),
      .RISE     (rise_q[i]),
      .FALL     (fall_q[i]),
      .PWM      (PWM_OUT[i])
    );
  end
`else
  assign PWM_OUT = '0;
  logic unused_time_cnt;
  assign unused_time_cnt = ^TIME_CNT;
`endif

endmodule

// File: tb/tb_pwm_preconditioner.sv
// Bench for pwm_preconditioner: directed scenarios plus randomized traffic, checked
// against a transaction-level reference model of commits and PWM windows.
module tb_pwm_preconditioner;

  localparam int N = 249;

`ifdef PWM_OUTPUT_EN
  localparam bit PwmEn = 1'b1;
`else
  localparam bit PwmEn = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic [8:0]          time_cnt;
  logic                upd;
  logic                in_valid;
  logic [N-1:0][7:0]   dutys;
  logic [N-1:0][7:0]   phases;
  logic [N-1:0][8:0]   rise;
  logic [N-1:0][8:0]   fall;
  logic                out_valid;
  logic [N-1:0]        pwm_out;

  always #5 clk = ~clk;

  pwm_preconditioner #(
    .TRANS_NUM (N)
  ) u_dut (
    .CLK       (clk),
    .RST       (rst),
    .TIME_CNT  (time_cnt),
    .UPDATE    (upd),
    .IN_VALID  (in_valid),
    .DUTYS     (dutys),
    .PHASES    (phases),
    .RISE      (rise),
    .FALL      (fall),
    .OUT_VALID (out_valid),
    .PWM_OUT   (pwm_out)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int     exp_rise  [N];
  int     exp_fall  [N];
  int     pend_rise [N];
  int     pend_fall [N];
  bit     pend_valid = 1'b0;
  longint pend_ready = 0;
  longint edge_no    = 0;
  bit     exp_ov     = 1'b0;
  bit [N-1:0] exp_pwm = '0;

  int ov_count   = 0;
  int pwm0_high  = 0;

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int ref_rise(input int ph, input int du);
    int r;
    r = (2 * ph - du / 2) % 512;
    if (r < 0) r += 512;
    return r;
  endfunction

  function automatic int ref_fall(input int ph, input int du);
    return (ref_rise(ph, du) + du) % 512;
  endfunction

  // High when t lies inside the window of length (fall-rise) mod 512 starting at rise.
  function automatic bit ref_on(input int t, input int r, input int f);
    return ((t - r + 512) % 512) < ((f - r + 512) % 512);
  endfunction

  task automatic model_edge();
    bit [N-1:0] nxt_pwm;
    edge_no++;
    for (int i = 0; i < N; i++) nxt_pwm[i] = PwmEn && ref_on(int'(time_cnt), exp_rise[i], exp_fall[i]);
    exp_ov = 1'b0;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        exp_rise[i] = 0;
        exp_fall[i] = 0;
      end
      pend_valid = 1'b0;
      nxt_pwm    = '0;
    end else begin
      if (upd && pend_valid && edge_no > pend_ready) begin
        for (int i = 0; i < N; i++) begin
          exp_rise[i] = pend_rise[i];
          exp_fall[i] = pend_fall[i];
        end
        exp_ov     = 1'b1;
        pend_valid = 1'b0;
      end
      if (in_valid) begin
        for (int i = 0; i < N; i++) begin
          pend_rise[i] = ref_rise(int'(phases[i]), int'(dutys[i]));
          pend_fall[i] = ref_fall(int'(phases[i]), int'(dutys[i]));
        end
        pend_valid = 1'b1;
        pend_ready = edge_no + N;
      end
    end
    exp_pwm = nxt_pwm;
  endtask

  task automatic tick();
    int ch;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq("out_valid", out_valid, exp_ov);
    check_eq("pwm_out", pwm_out, exp_pwm);
    ch = $urandom_range(0, N - 1);
    check_eq("rise_rand", rise[ch], exp_rise[ch]);
    check_eq("fall_rand", fall[ch], exp_fall[ch]);
    if (out_valid) ov_count++;
    if (pwm_out[0]) pwm0_high++;
    in_valid = 1'b0;
    rst      = 1'b0;
    time_cnt = time_cnt + 9'd1;
    upd      = (time_cnt == 9'd511);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic align_to(input int t);
    for (int i = 0; i < 512 && int'(time_cnt) != t; i++) tick();
  endtask

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      check_eq("rise_all", rise[i], exp_rise[i]);
      check_eq("fall_all", fall[i], exp_fall[i]);
    end
  endtask

  task automatic set_all(input logic [7:0] du, input logic [7:0] ph);
    for (int i = 0; i < N; i++) begin
      dutys[i]  = du;
      phases[i] = ph;
    end
  endtask

  task automatic set_random();
    for (int i = 0; i < N; i++) begin
      dutys[i]  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      phases[i] = 8'($urandom);
    end
  endtask

  // Waits (bounded) for the next OUT_VALID pulse.
  task automatic wait_commit(input string tag);
    ov_count = 0;
    for (int i = 0; i < 1200 && ov_count == 0; i++) tick();
    check_eq(tag, ov_count, 1);
  endtask

  initial begin
    rst      = 1'b1;
    time_cnt = 9'd0;
    upd      = 1'b0;
    in_valid = 1'b0;
    dutys    = '0;
    phases   = '0;
    for (int i = 0; i < N; i++) begin
      exp_rise[i] = 0;
      exp_fall[i] = 0;
    end

    // Reset state
    rst = 1'b1; tick();
    rst = 1'b1; tick();
    rst = 1'b1; tick();
    check_eq("reset_rise0", rise[0], 0);
    check_eq("reset_fall_last", fall[N-1], 0);
    check_eq("reset_ov", out_valid, 0);

    // Centred pulse: phase 0x40, duty 0x20
    set_all(8'h20, 8'h40);
    in_valid = 1'b1; tick();
    wait_commit("s1_commit");
    check_eq("s1_rise0", rise[0], 112);
    check_eq("s1_fall_last", fall[N-1], 144);
    check_all();
    pwm0_high = 0;
    run(512);
    check_eq("s1_pwm_width", pwm0_high, PwmEn ? 32 : 0);

    // Window wrapping through the period end
    set_all(8'h10, 8'h00);
    in_valid = 1'b1; tick();
    wait_commit("s2_commit");
    check_eq("s2_rise0", rise[0], 504);
    check_eq("s2_fall0", fall[0], 8);
    pwm0_high = 0;
    run(512);
    check_eq("s2_pwm_width", pwm0_high, PwmEn ? 16 : 0);

    // Zero duty: off
    set_all(8'h00, 8'h80);
    in_valid = 1'b1; tick();
    wait_commit("s3_commit");
    check_eq("s3_rise0", rise[0], 256);
    check_eq("s3_fall0", fall[0], 256);
    pwm0_high = 0;
    run(3 * 512);
    check_eq("s3_pwm_width", pwm0_high, 0);

    // Last CALC index coincides with UPDATE: commit deferred one full period
    align_to(511 - N);
    set_random();
    in_valid = 1'b1; tick();
    ov_count = 0;
    run(300);
    check_eq("s4_no_early_commit", ov_count, 0);
    run(512);
    check_eq("s4_late_commit", ov_count, 1);
    check_all();

    // Restart at index 100: only the second set is committed
    align_to(0);
    ov_count = 0;
    set_random();
    in_valid = 1'b1; tick();
    run(100);
    set_random();
    in_valid = 1'b1; tick();
    run(900);
    check_eq("s5_single_commit", ov_count, 1);
    check_all();

    // Reset mid-CALC: everything cleared, no later commit
    set_random();
    in_valid = 1'b1; tick();
    run(50);
    rst = 1'b1; tick();
    ov_count  = 0;
    pwm0_high = 0;
    run(1100);
    check_eq("s6_no_commit", ov_count, 0);
    check_eq("s6_pwm0", pwm0_high, 0);
    check_eq("s6_rise_mid", rise[N/2], 0);
    check_all();

    // IN_VALID together with UPDATE in WAIT_UPDATE: old set commits, new set follows
    align_to(0);
    set_random();
    in_valid = 1'b1; tick();
    align_to(511);
    set_random();
    in_valid = 1'b1;
    ov_count = 0;
    tick();
    check_eq("s7_old_commit", ov_count, 1);
    check_all();
    run(600);
    check_eq("s7_new_commit", ov_count, 2);
    check_all();

    // Random traffic
    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        set_random();
        in_valid = 1'b1;
      end
      if ($urandom_range(0, 3999) == 0) rst = 1'b1;
      tick();
    end
    check_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
